// File: rtl/ecc_mon_pkg.sv
// ecc_mon_pkg: shared status FSM encoding and err_type codes for the ECC read-error monitor.
package ecc_mon_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        SBIT_LOGGED = 2'b01,
        DBIT_LOGGED = 2'b10
    } ecc_mon_state_e;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SBIT = 2'b01;
    localparam logic [1:0] ERR_DBIT = 2'b10;

endpackage

// File: rtl/ecc_mon_skid_buf.sv
// ecc_mon_skid_buf: 2-entry valid/ready stage with registered in_ready, 1-cycle latency, full throughput.
module ecc_mon_skid_buf #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_ready_q, in_ready_d;
    logic             acc, out_load;

    // The output register reloads whenever it is empty or draining; the skid only fills when it cannot.
    always_comb begin
        acc          = in_valid & in_ready_q;
        out_load     = !out_valid_q | out_ready;
        out_valid_d  = out_load ? (skid_valid_q | acc) : out_valid_q;
        out_data_d   = out_load ? (skid_valid_q ? skid_data_q : in_data) : out_data_q;
        skid_valid_d = out_load ? 1'b0 : (skid_valid_q | acc);
        skid_data_d  = (!out_load && acc) ? in_data : skid_data_q;
        in_ready_d   = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/ecc_rd_err_monitor.sv
// ecc_rd_err_monitor: forwards decoded beats via a skid stage, counts sbit/dbit events, logs first error, raises irq.
// Define ECC_MON_DBIT_DROP_EN to count/capture dbit beats without forwarding them (out_dbit tied 0).
module ecc_rd_err_monitor
    import ecc_mon_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_dbit,
    input  logic                  clr,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [1:0]            err_type,
    output logic                  irq
);

    logic                  fwd_valid;
    logic [DATA_WIDTH:0]   fwd_payload;
    logic                  acc, sbit_hit, dbit_hit;
    logic [CNT_WIDTH-1:0]  sbit_base, dbit_base;
    logic [CNT_WIDTH-1:0]  sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [1:0]            err_type_q, err_type_d;
    logic                  irq_q, irq_d;
    ecc_mon_state_e        state_q, state_d, state_base;

`ifdef ECC_MON_DBIT_DROP_EN
    assign fwd_valid = in_valid & !in_dbit_err;
    assign out_dbit  = 1'b0;
`else
    assign fwd_valid = in_valid;
    assign out_dbit  = fwd_payload[DATA_WIDTH];
`endif

    ecc_mon_skid_buf #(.WIDTH(DATA_WIDTH + 1)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (fwd_valid),
        .in_ready  (in_ready),
        .in_data   ({in_dbit_err, in_data}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (fwd_payload)
    );

    assign out_data = fwd_payload[DATA_WIDTH-1:0];

    // clr is folded in before the accepted beat so a same-cycle error lands on a cleared state.
    always_comb begin
        acc        = in_valid & in_ready;
        dbit_hit   = acc & in_dbit_err;
        sbit_hit   = acc & in_sbit_err & !in_dbit_err;
        sbit_base  = clr ? '0 : sbit_cnt_q;
        dbit_base  = clr ? '0 : dbit_cnt_q;
        sbit_cnt_d = (sbit_hit && sbit_base != '1) ? sbit_base + CNT_WIDTH'(1) : sbit_base;
        dbit_cnt_d = (dbit_hit && dbit_base != '1) ? dbit_base + CNT_WIDTH'(1) : dbit_base;
        state_base = clr ? IDLE : state_q;
        state_d    = state_base;
        err_addr_d = clr ? '0 : err_addr_q;
        if (dbit_hit && state_base != DBIT_LOGGED) begin
            state_d    = DBIT_LOGGED;
            err_addr_d = in_addr;
        end else if (sbit_hit && state_base == IDLE) begin
            state_d    = SBIT_LOGGED;
            err_addr_d = in_addr;
        end
        err_type_d = (state_d == DBIT_LOGGED) ? ERR_DBIT : (state_d == SBIT_LOGGED) ? ERR_SBIT : ERR_NONE;
        irq_d      = state_d != IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sbit_cnt_q <= '0;
            dbit_cnt_q <= '0;
            err_addr_q <= '0;
            err_type_q <= ERR_NONE;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sbit_cnt_q <= sbit_cnt_d;
            dbit_cnt_q <= dbit_cnt_d;
            err_addr_q <= err_addr_d;
            err_type_q <= err_type_d;
            irq_q      <= irq_d;
        end
    end

    assign sbit_cnt = sbit_cnt_q;
    assign dbit_cnt = dbit_cnt_q;
    assign err_addr = err_addr_q;
    assign err_type = err_type_q;
    assign irq      = irq_q;

endmodule
